alu_pipe: RTL

Parametrised, handshaked ALU: the word-level successor to the 1-bit ALU slice. It performs AND/OR/NOR/ADD/SUB and the six signed compare variants in one cycle, and an iterative shift-add multiply over WIDTH cycles. It sits between the decode stage and the register-file write-back. Operands enter on a valid/ready handshake, and results are held in an output register until the consumer takes them.

---
 rtl/alu_pipe.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Handshaked word-level ALU: one-cycle logic/arith/compare ops and an iterative
// shift-add multiply, with a held output register released by the consumer.
module alu_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic [3:0]       op_i,
   input  logic [2:0]       cmp_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             cout_o,
   output logic             overflow_o,
   output logic             illegal_o
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_CMP = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state, next_state;

   logic [CW-1:0]    count;
   logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
   logic             accept, is_mul, last_iter;

   logic             sub;
   logic [WIDTH-1:0] b_op;
   logic [WIDTH:0]   full_sum;
   logic             carry_msb_in, add_ovf, less, equal, cmp_bit;

   logic [WIDTH-1:0] alu_result;
   logic             alu_cout, alu_ovf, alu_illegal;

   assign in_ready_o = (state != BUSY) && (!out_valid_o || out_ready_i);
   assign accept     = in_valid_i && in_ready_o;
   assign is_mul     = (op_i == OP_MUL);
   assign last_iter  = (state == BUSY) && (count == CW'(1));

   // SUB and CMP share the adder as src1 + ~src2 + 1; the MSB carry-in is
   // recovered from the sum bit so only one adder is needed.
   assign sub          = (op_i == OP_SUB) || (op_i == OP_CMP);
   assign b_op         = sub ? ~src2_i : src2_i;
   assign full_sum     = {1'b0, src1_i} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
   assign carry_msb_in = full_sum[WIDTH-1] ^ src1_i[WIDTH-1] ^ b_op[WIDTH-1];
   assign add_ovf      = carry_msb_in ^ full_sum[WIDTH];
   assign less         = full_sum[WIDTH-1] ^ add_ovf;
   assign equal        = (src1_i == src2_i);

   assign acc_next = mplier[0] ? acc + mcand : acc;

   // State register; a reset abandons any multiply in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept && is_mul) next_state = BUSY;
         BUSY: if (count == CW'(1))  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Single-cycle result selection.
   always_comb begin
      alu_result  = '0;
      alu_cout    = 1'b0;
      alu_ovf     = 1'b0;
      alu_illegal = 1'b0;
      cmp_bit     = 1'b0;
      case (op_i)
         OP_AND: alu_result = src1_i & src2_i;
         OP_OR:  alu_result = src1_i | src2_i;
         OP_NOR: alu_result = ~(src1_i | src2_i);
         OP_ADD, OP_SUB: begin
            alu_result = full_sum[WIDTH-1:0];
            alu_cout   = full_sum[WIDTH];
            alu_ovf    = add_ovf;
         end
         OP_CMP: begin
            case (cmp_i)
               3'd0:    cmp_bit = less;
               3'd1:    cmp_bit = !less && !equal;
               3'd2:    cmp_bit = less || equal;
               3'd3:    cmp_bit = !less;
               3'd4:    cmp_bit = equal;
               3'd5:    cmp_bit = !equal;
               default: cmp_bit = 1'b0;
            endcase
            alu_result = {{(WIDTH-1){1'b0}}, cmp_bit};
         end
         OP_MUL: alu_result = '0;
         default: alu_illegal = 1'b1;
      endcase
   end

   // Multiplier: multiplicand shifts left while multiplier bits are consumed LSB first.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (accept && is_mul) begin
         count  <= CW'(WIDTH);
         mcand  <= src1_i;
         mplier <= src2_i;
         acc    <= '0;
      end else if (state == BUSY) begin
         count  <= count - CW'(1);
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         acc    <= acc_next;
      end
   end

   // Output register: a completing result wins over a take on the same edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_o <= 1'b0;
         result_o    <= '0;
         zero_o      <= 1'b1;
         cout_o      <= 1'b0;
         overflow_o  <= 1'b0;
         illegal_o   <= 1'b0;
      end else if (last_iter) begin
         out_valid_o <= 1'b1;
         result_o    <= acc_next;
         zero_o      <= (acc_next == '0);
         cout_o      <= 1'b0;
         overflow_o  <= 1'b0;
         illegal_o   <= 1'b0;
      end else if (accept && !is_mul) begin
         out_valid_o <= 1'b1;
         result_o    <= alu_result;
         zero_o      <= (alu_result == '0);
         cout_o      <= alu_cout;
         overflow_o  <= alu_ovf;
         illegal_o   <= alu_illegal;
      end else if (out_ready_i) begin
         out_valid_o <= 1'b0;
      end
   end

endmodule
